instruction_memory_pl: RTL and testbench
========================================

INSTRUCTION_MEMORY_PL -- requirements
Module: instruction_memory_pl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: instruction word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 64: number of words, any value from 2 to 4096.
REQ-003 SHALL provide parameter AW, default $clog2(DEPTH): address width.
REQ-004 SHALL provide parameter NOP, default 32'h0007_8000: fill and fault word.
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rd_en  input  1  read request.
REQ-008 address  input  AW  read word address.
REQ-009 out_data  output  WIDTH  registered read data.
REQ-010 out_valid  output  1  out_data was updated by a read accepted on the previous cycle.
REQ-011 addr_fault  output  1  previous accepted read was out of range.
REQ-012 ld_start  input  1  request to begin program load.
REQ-013 ld_valid  input  1  ld_data is valid.
REQ-014 ld_data  input  WIDTH  word to load.
REQ-015 ld_last  input  1  marks the final load word.
REQ-016 ld_ready  output  1  block accepts a load word this cycle.
REQ-017 ld_done  output  1  one-cycle pulse when a load completes.
REQ-018 busy  output  1  block is in INIT or LOAD.

Function
REQ-019 SHALL implement the FSM states INIT, RUN and LOAD.
REQ-020 INIT: each cycle SHALL write NOP to mem[clr_cnt] and increment clr_cnt; after writing DEPTH-1 it SHALL enter RUN, so INIT lasts exactly DEPTH cycles.
REQ-021 INIT: rd_en, ld_start and ld_valid SHALL be ignored; busy=1 and ld_ready=0.
REQ-022 RUN, rd_en=1, address<DEPTH: next cycle out_data=mem[address], out_valid=1, addr_fault=0 (latency 1).
REQ-023 RUN, rd_en=1, address>=DEPTH: next cycle out_data=NOP, out_valid=1, addr_fault=1; no memory access.
REQ-024 rd_en=0 or no read accepted: out_data SHALL hold its value; out_valid=0 and addr_fault=0 next cycle.
REQ-025 RUN, ld_start=1: next state SHALL be LOAD with ld_ptr=0; ld_start SHALL take priority, so a same-cycle rd_en is not accepted.
REQ-026 LOAD: ld_ready=1 and busy=1; reads SHALL NOT be accepted; ld_start SHALL be ignored.
REQ-027 LOAD, ld_valid&ld_ready: mem[ld_ptr]=ld_data, then ld_ptr SHALL increment.
REQ-028 LOAD: a write with ld_last=1 or ld_ptr=DEPTH-1 SHALL end the load; next cycle state=RUN, ld_ready=0 and ld_done=1 for exactly one cycle.
REQ-029 Words not written during a LOAD SHALL retain their prior contents.
REQ-030 ld_ptr SHALL never wrap; ld_valid without a valid handshake (ld_ready=0) SHALL have no effect.
REQ-031 busy SHALL be a registered decode of the state (1 in INIT/LOAD, 0 in RUN).

Reset
REQ-032 reset=0 SHALL asynchronously force state=INIT, clr_cnt=0, ld_ptr=0, out_data=NOP, out_valid=0, addr_fault=0, ld_ready=0, ld_done=0, busy=1.
REQ-033 Reset asserted mid-LOAD or mid-INIT SHALL abort the operation; after release the full INIT SHALL rerun, leaving all words NOP.
REQ-034 The memory array SHALL NOT be reset directly; it is cleared only by INIT.

Verification
REQ-035 Reset release, DEPTH=64: busy=1 for 64 cycles then 0; read of addr 0..63 -> every out_data=32'h00078000, out_valid=1 one cycle after each request.
REQ-036 ld_start, then 3 words 32'h80080001, 32'h82100001, 32'h021D0400 (third with ld_last) -> ld_done one cycle after the third write; read addr 1 -> 32'h82100001; read addr 3 -> NOP.
REQ-037 64-word load with no ld_last and ld_valid toggled every other cycle -> exactly 64 writes; ld_done after word 63; addr 63 holds the last word; no wrap to addr 0.
REQ-038 DEPTH=48, AW=6, read addr 50 -> out_data=NOP, addr_fault=1 for one cycle; read addr 47 -> addr_fault=0.
REQ-039 ld_start and rd_en both high in RUN -> no out_valid next cycle; state LOAD, ld_ready=1.
REQ-040 reset pulsed after 2 of 5 load words -> INIT reruns (64 busy cycles); all addresses read back NOP; ld_done never pulses.

Source files
------------

// File: rtl/instruction_memory_pl.sv
// Instruction memory with a power-on NOP fill sweep, a one-cycle-latency read port
// and a streaming program-load port sharing one write port.
module instruction_memory_pl #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 64,
  parameter int               AW    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h0007_8000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [AW-1:0]    address,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             addr_fault,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]    ld_ptr_q, ld_ptr_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             addr_fault_q;
  logic             ld_ready_q;
  logic             ld_done_q;
  logic             busy_q;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             rd_acc;
  logic             rd_in_range;
  logic             ld_end;

  // Widened compare so non-power-of-two depths can flag the unused top addresses.
  assign rd_in_range = ({1'b0, address} < DEPTH_EXT);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ld_ptr_d  = ld_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = NOP;
    rd_acc    = 1'b0;
    ld_end    = 1'b0;

    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (ld_start) begin
          state_d  = S_LOAD;
          ld_ptr_d = '0;
        end else begin
          rd_acc = rd_en;
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          mem_we    = 1'b1;
          mem_waddr = ld_ptr_q;
          mem_wdata = ld_data;
          // Hold the pointer on the final slot rather than letting it wrap.
          if (ld_last || (ld_ptr_q == LAST_ADDR)) begin
            ld_end  = 1'b1;
            state_d = S_RUN;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT;
      clr_cnt_q    <= '0;
      ld_ptr_q     <= '0;
      out_data_q   <= NOP;
      out_valid_q  <= 1'b0;
      addr_fault_q <= 1'b0;
      ld_ready_q   <= 1'b0;
      ld_done_q    <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      ld_ptr_q     <= ld_ptr_d;
      out_valid_q  <= rd_acc;
      addr_fault_q <= rd_acc && !rd_in_range;
      ld_ready_q   <= (state_d == S_LOAD);
      ld_done_q    <= ld_end;
      busy_q       <= (state_d != S_RUN);
      if (rd_acc) begin
        out_data_q <= rd_in_range ? mem[address] : NOP;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign addr_fault = addr_fault_q;
  assign ld_ready   = ld_ready_q;
  assign ld_done    = ld_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_instruction_memory_pl.sv
// Scoreboard bench for instruction_memory_pl: a 64-word instance for fill/load/read
// behaviour and a 48-word instance for out-of-range address faults.
module tb_instruction_memory_pl;

  localparam int          D     = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP_W = 32'h0007_8000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   out_data;
  logic          out_valid, addr_fault;
  logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready, ld_done, busy;

  logic          rd48 = 1'b0;
  logic [5:0]    addr48 = '0;
  logic [31:0]   out48;
  logic          valid48, fault48, ready48, done48, busy48;
  logic          zero_bit = 1'b0;
  logic [31:0]   zero_word = '0;

  instruction_memory_pl u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .address(address),
    .out_data(out_data), .out_valid(out_valid), .addr_fault(addr_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
  );

  instruction_memory_pl #(.DEPTH(48), .AW(6)) u_dut48 (
    .clk(clk), .reset(reset), .rd_en(rd48), .address(addr48),
    .out_data(out48), .out_valid(valid48), .addr_fault(fault48),
    .ld_start(zero_bit), .ld_valid(zero_bit), .ld_data(zero_word), .ld_last(zero_bit),
    .ld_ready(ready48), .ld_done(done48), .busy(busy48)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [D];
  int          exp_done_cyc = -1;
  bit          mon_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: out_valid must match the scoreboard, read data is popped and compared.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic exp_v;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check_eq("sb_late", 32'(e.due), 32'(cyc));
      end
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check_eq("out_valid", 32'(out_valid), 32'(exp_v));
      check_eq("addr_fault", 32'(addr_fault), 32'(0));
      if (exp_v) begin
        e = sb.pop_front();
        check_eq("out_data", out_data, e.data);
        $display("cycle %0d read data %h expected %h", cyc, out_data, e.data);
      end
      check_eq("ld_done", 32'(ld_done), 32'(cyc == exp_done_cyc));
    end
  end

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_en   = 1'b1;
      address = AW'(a);
      sb.push_back('{due: cyc + 1, data: model_mem[a]});
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic load_words(input int n, input bit use_last, input bit gaps,
                            input logic [31:0] base);
    int ptr = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) begin
        ld_valid = 1'b0;
        tick();
      end
      check_eq("ld_ready_load", 32'(ld_ready), 32'(1));
      check_eq("busy_load", 32'(busy), 32'(1));
      ld_valid = 1'b1;
      ld_data  = base + 32'(k);
      ld_last  = use_last && (k == n - 1);
      model_mem[ptr] = ld_data;
      ptr++;
      if (ld_last || ptr == D) exp_done_cyc = cyc + 1;
      $display("cycle %0d load word %0d = %h", cyc, k, ld_data);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check_eq("ld_ready_after", 32'(ld_ready), 32'(0));
    check_eq("busy_after_load", 32'(busy), 32'(0));
  endtask

  task automatic count_busy(output int n64, output int n48);
    n64 = 0;
    n48 = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) n64++;
      if (busy48) n48++;
      if (!busy && !busy48) break;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b64, b48;
    for (int i = 0; i < D; i++) model_mem[i] = NOP_W;

    // Reset values
    tick();
    tick();
    check_eq("rst_busy", 32'(busy), 32'(1));
    check_eq("rst_ld_ready", 32'(ld_ready), 32'(0));
    check_eq("rst_ld_done", 32'(ld_done), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_addr_fault", 32'(addr_fault), 32'(0));
    check_eq("rst_out_data", out_data, NOP_W);
    check_eq("rst_busy48", 32'(busy48), 32'(1));

    // Fill sweep length, then read every word back as NOP
    reset  = 1'b1;
    mon_en = 1'b1;
    count_busy(b64, b48);
    check_eq("init_cycles64", 32'(b64), 32'(64));
    check_eq("init_cycles48", 32'(b48), 32'(48));
    read_range(0, D - 1);
    tick();

    // Out-of-range and last-valid address on the 48-word instance
    rd48 = 1'b1; addr48 = 6'd50;
    tick();
    check_eq("d48_valid_50", 32'(valid48), 32'(1));
    check_eq("d48_fault_50", 32'(fault48), 32'(1));
    check_eq("d48_data_50", out48, NOP_W);
    addr48 = 6'd47;
    tick();
    check_eq("d48_valid_47", 32'(valid48), 32'(1));
    check_eq("d48_fault_47", 32'(fault48), 32'(0));
    check_eq("d48_data_47", out48, NOP_W);
    rd48 = 1'b0;
    tick();
    check_eq("d48_valid_idle", 32'(valid48), 32'(0));
    check_eq("d48_fault_idle", 32'(fault48), 32'(0));

    // Three-word load ending on ld_last
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    begin
      logic [31:0] prog [3];
      prog[0] = 32'h8008_0001; prog[1] = 32'h8210_0001; prog[2] = 32'h021D_0400;
      for (int k = 0; k < 3; k++) begin
        check_eq("ld_ready_prog", 32'(ld_ready), 32'(1));
        ld_valid = 1'b1; ld_data = prog[k]; ld_last = (k == 2);
        model_mem[k] = prog[k];
        if (k == 2) exp_done_cyc = cyc + 1;
        $display("cycle %0d load word %0d = %h", cyc, k, ld_data);
        tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
    end
    check_eq("ld_ready_prog_end", 32'(ld_ready), 32'(0));
    read_range(0, 3);
    tick();
    tick();
    check_eq("out_hold", out_data, NOP_W);

    // Full-depth load, no ld_last, ld_valid toggling; an extra word afterwards must be ignored
    load_words(D, 1'b0, 1'b1, 32'hA500_0000);
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_valid = 1'b0;
    read_range(0, D - 1);
    tick();

    // ld_start with rd_en: load wins; reads and ld_start ignored while loading
    ld_start = 1'b1; rd_en = 1'b1; address = 6'd2;
    tick();
    check_eq("prio_ld_ready", 32'(ld_ready), 32'(1));
    check_eq("prio_busy", 32'(busy), 32'(1));
    address = 6'd3;
    ld_valid = 1'b1; ld_data = 32'h1111_2222; model_mem[0] = ld_data;
    tick();
    check_eq("prio_ld_ready2", 32'(ld_ready), 32'(1));
    ld_data = 32'h3333_4444; ld_last = 1'b1; model_mem[1] = ld_data;
    exp_done_cyc = cyc + 1;
    tick();
    ld_start = 1'b0; rd_en = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    check_eq("prio_ld_ready_end", 32'(ld_ready), 32'(0));
    check_eq("prio_busy_end", 32'(busy), 32'(0));
    read_range(0, 3);
    tick();
    tick();
    check_eq("out_hold2", out_data, model_mem[3]);

    // Reset in the middle of a five-word load
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1; ld_data = 32'h5500_0000 + 32'(k);
      $display("cycle %0d load word %0d = %h", cyc, k, ld_data);
      tick();
    end
    ld_data = 32'h5500_0002;
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'(1));
    check_eq("midrst_ld_ready", 32'(ld_ready), 32'(0));
    check_eq("midrst_out_data", out_data, NOP_W);
    check_eq("midrst_ld_done", 32'(ld_done), 32'(0));
    ld_valid = 1'b0;
    sb.delete();
    exp_done_cyc = -1;
    for (int i = 0; i < D; i++) model_mem[i] = NOP_W;
    tick();
    tick();
    reset = 1'b1;
    count_busy(b64, b48);
    check_eq("reinit_cycles64", 32'(b64), 32'(64));
    check_eq("reinit_cycles48", 32'(b48), 32'(48));
    read_range(0, D - 1);

    tick();
    tick();
    tick();
    check_eq("sb_drain", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
